// File: rtl/nonce_sweep_ctrl_pkg.sv
// Shared types and defaults for the nonce sweep controller.
// State encoding and default widths.
package nonce_sweep_ctrl_pkg;

    localparam int NONCE_W_DEF = 32;
    localparam int CMP_W_DEF   = 64;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_REPORT
    } state_t;

endpackage

// File: rtl/nonce_sweep_ctrl_cmp.sv
// Unsigned hash-vs-target comparator.
// A hash wins when it is not above the target.
module hash_target_cmp
    import nonce_sweep_ctrl_pkg::*;
#(
    parameter int CMP_W = CMP_W_DEF
) (
    input  logic [CMP_W-1:0] hash,
    input  logic [CMP_W-1:0] target,
    output logic             hit
);

    // Pure combinational compare.
    assign hit = (hash <= target);

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps one hash core across a nonce range for a single job.
// Reports first hit, exhaustion or abort on a valid/ready port.
module nonce_sweep_ctrl
    import nonce_sweep_ctrl_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int CMP_W   = CMP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [NONCE_W-1:0] job_nonce_start,
    input  logic [NONCE_W-1:0] job_nonce_end,
    input  logic [CMP_W-1:0]   job_target,
    input  logic               abort,
    output logic               core_start,
    output logic [NONCE_W-1:0] core_nonce,
    input  logic               core_done,
    input  logic [CMP_W-1:0]   core_hash_msb,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_found,
    output logic               res_aborted,
    output logic [NONCE_W-1:0] res_nonce,
    output logic               busy,
    output logic [CNT_W-1:0]   hashes_done
);

    state_t             state;
    logic [NONCE_W-1:0] cur;
    logic [NONCE_W-1:0] end_q;
    logic [CMP_W-1:0]   target_q;
    logic               hit;

    hash_target_cmp #(
        .CMP_W (CMP_W)
    ) u_cmp (
        .hash   (core_hash_msb),
        .target (target_q),
        .hit    (hit)
    );

    // Nonce register doubles as the request nonce; it only moves in WAIT.
    assign core_nonce = cur;

    // Sweep FSM with registered handshake, result and statistics outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            job_ready   <= 1'b1;
            busy        <= 1'b0;
            core_start  <= 1'b0;
            cur         <= '0;
            end_q       <= '0;
            target_q    <= '0;
            res_valid   <= 1'b0;
            res_found   <= 1'b0;
            res_aborted <= 1'b0;
            res_nonce   <= '0;
            hashes_done <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (job_valid) begin
                        end_q     <= job_nonce_end;
                        target_q  <= job_target;
                        cur       <= job_nonce_start;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (job_nonce_start > job_nonce_end) begin
                            state       <= ST_REPORT;
                            res_valid   <= 1'b1;
                            res_found   <= 1'b0;
                            res_aborted <= 1'b0;
                            res_nonce   <= job_nonce_start;
                        end else begin
                            state      <= ST_ISSUE;
                            core_start <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= abort ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        if (hashes_done != '1)
                            hashes_done <= hashes_done + CNT_W'(1);
                        if (hit || cur == end_q || abort) begin
                            state       <= ST_REPORT;
                            res_valid   <= 1'b1;
                            res_found   <= hit;
                            res_aborted <= !hit && cur != end_q;
                            res_nonce   <= cur;
                        end else begin
                            cur        <= cur + NONCE_W'(1);
                            state      <= ST_ISSUE;
                            core_start <= 1'b1;
                        end
                    end else if (abort) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (core_done) begin
                        if (hashes_done != '1)
                            hashes_done <= hashes_done + CNT_W'(1);
                        state       <= ST_REPORT;
                        res_valid   <= 1'b1;
                        res_found   <= 1'b0;
                        res_aborted <= 1'b1;
                        res_nonce   <= cur;
                    end
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        job_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Directed bench for nonce_sweep_ctrl with a latency-3 core model.
// Expected requests/results are queued at job submit and popped on output.
module tb_nonce_sweep_ctrl;

    typedef struct packed {
        logic        found;
        logic        aborted;
        logic [31:0] nonce;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_nonce_start = '0;
    logic [31:0] job_nonce_end = '0;
    logic [63:0] job_target = '0;
    logic        abort = 1'b0;
    logic        core_start;
    logic [31:0] core_nonce;
    logic        core_done = 1'b0;
    logic [63:0] core_hash_msb = '0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic        res_found;
    logic        res_aborted;
    logic [31:0] res_nonce;
    logic        busy;
    logic [31:0] hashes_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_starts[$];
    res_t        exp_res[$];
    logic [31:0] exp_hashes = '0;

    logic        hit_en = 1'b0;
    logic [31:0] hit_nonce = '0;
    logic [31:0] m_nonce = '0;
    int          m_cnt = 0;

    nonce_sweep_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_nonce_start (job_nonce_start),
        .job_nonce_end   (job_nonce_end),
        .job_target      (job_target),
        .abort           (abort),
        .core_start      (core_start),
        .core_nonce      (core_nonce),
        .core_done       (core_done),
        .core_hash_msb   (core_hash_msb),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_found       (res_found),
        .res_aborted     (res_aborted),
        .res_nonce       (res_nonce),
        .busy            (busy),
        .hashes_done     (hashes_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model: done pulse a few cycles after each start.
    always @(negedge clk) begin
        if (core_done) core_done = 1'b0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                core_done = 1'b1;
                core_hash_msb = (hit_en && m_nonce == hit_nonce) ? 64'd0 : '1;
            end
        end
        if (core_start) begin
            m_nonce = core_nonce;
            m_cnt = 3;
        end
    end

    // Request monitor: every start must match the next expected nonce.
    always @(negedge clk) begin
        if (core_start) begin
            if (exp_starts.size() == 0) begin
                chk("unexpected_start", {32'd0, core_nonce}, 64'hdead);
            end else begin
                chk("start_nonce", {32'd0, core_nonce},
                    {32'd0, exp_starts.pop_front()});
            end
        end
    end

    // Result monitor: compare on each accepted handshake.
    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                chk("unexpected_result", {32'd0, res_nonce}, 64'hdead);
            end else begin
                res_t e;
                e = exp_res.pop_front();
                chk("res_found", {63'd0, res_found}, {63'd0, e.found});
                chk("res_aborted", {63'd0, res_aborted}, {63'd0, e.aborted});
                chk("res_nonce", {32'd0, res_nonce}, {32'd0, e.nonce});
            end
        end
    end

    // Reference sweep: queue the expected requests and final result.
    task automatic plan(input logic [31:0] s, input logic [31:0] e);
        logic [31:0] n;
        res_t r;
        if (s > e) begin
            r = '{found: 1'b0, aborted: 1'b0, nonce: s};
        end else begin
            n = s;
            forever begin
                exp_starts.push_back(n);
                exp_hashes++;
                if (hit_en && n == hit_nonce) begin
                    r = '{found: 1'b1, aborted: 1'b0, nonce: n};
                    break;
                end
                if (n == e) begin
                    r = '{found: 1'b0, aborted: 1'b0, nonce: n};
                    break;
                end
                n++;
            end
        end
        exp_res.push_back(r);
    endtask

    task automatic send_job(input logic [31:0] s, input logic [31:0] e);
        @(negedge clk);
        job_nonce_start = s;
        job_nonce_end = e;
        job_target = 64'd0;
        job_valid = 1'b1;
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (exp_res.size() == 0 && !busy) break;
        end
        chk({tag, "_res_left"}, 64'(exp_res.size()), 64'd0);
        chk({tag, "_starts_left"}, 64'(exp_starts.size()), 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_hashes"}, {32'd0, hashes_done}, {32'd0, exp_hashes});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_job_ready", {63'd0, job_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_core_start", {63'd0, core_start}, 64'd0);
        chk("rst_hashes", {32'd0, hashes_done}, 64'd0);

        // 1: full sweep, no hit
        hit_en = 1'b0;
        plan(32'h10, 32'h13);
        send_job(32'h10, 32'h13);
        wait_idle("t1");

        // 2: hit at 0x12 stops the sweep
        hit_en = 1'b1;
        hit_nonce = 32'h12;
        plan(32'h10, 32'h13);
        send_job(32'h10, 32'h13);
        wait_idle("t2");
        hit_en = 1'b0;

        // 3: top of nonce space, no wrap
        plan(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        send_job(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        wait_idle("t3");

        // 4: abort during the first ISSUE
        exp_starts.push_back(32'd5);
        exp_hashes++;
        exp_res.push_back('{found: 1'b0, aborted: 1'b1, nonce: 32'd5});
        send_job(32'd5, 32'd8);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (core_done) break;
        end
        chk("t4_done_seen", {63'd0, core_done}, 64'd1);
        chk("t4_no_res_yet", {63'd0, res_valid}, 64'd0);
        @(negedge clk);
        #1;
        chk("t4_res_next", {63'd0, res_valid}, 64'd1);
        wait_idle("t4");

        // 5: empty range reports start nonce without a request
        plan(32'd9, 32'd3);
        send_job(32'd9, 32'd3);
        @(negedge clk);
        chk("t5_res_fast", {63'd0, res_valid}, 64'd1);
        wait_idle("t5");

        // 6: consumer stall holds the result
        res_ready = 1'b0;
        plan(32'h20, 32'h20);
        send_job(32'h20, 32'h20);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid) break;
        end
        for (int k = 0; k < 10; k++) begin
            chk("t6_valid", {63'd0, res_valid}, 64'd1);
            chk("t6_nonce", {32'd0, res_nonce}, 64'h20);
            chk("t6_found", {63'd0, res_found}, 64'd0);
            chk("t6_job_ready", {63'd0, job_ready}, 64'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_idle("t6");

        // Reset while waiting on the core
        exp_starts.push_back(32'h30);
        send_job(32'h30, 32'h35);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_job_ready", {63'd0, job_ready}, 64'd1);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        repeat (6) @(negedge clk);
        chk("rst_late_done_hashes", {32'd0, hashes_done}, 64'd0);
        chk("rst_late_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_starts_left", 64'(exp_starts.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
